// File: rtl/tmds_pll_pkg.sv
// Shared types and constants for the TMDS PLL controller: state encoding and
// the per-mode divider selects for a 27 MHz reference.
package tmds_pll_pkg;

  localparam int MODE_W = 2;
  localparam int SEL_W  = 6;

  typedef enum logic [2:0] {
    ST_RESET_HOLD,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0] idsel;
    logic [SEL_W-1:0] fbdsel;
    logic [SEL_W-1:0] odsel;
  } pll_sel_t;

  // Selects are pre-encoded as (64 - divider); TMDS clock = 5x pixel clock.
  // 480p 135 MHz: /1 x5 /4; 720p and 1080i 371.25 MHz: /4 x55 /2;
  // 1024x768 ~324 MHz: /1 x12 /2.
  localparam pll_sel_t MODE_TABLE [0:3] = '{
    '{6'd63, 6'd59, 6'd60},
    '{6'd60, 6'd9,  6'd62},
    '{6'd60, 6'd9,  6'd62},
    '{6'd63, 6'd52, 6'd62}
  };

endpackage

// File: rtl/tmds_pll_ctrl_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into clkin.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/tmds_pll_ctrl.sv
// PLL bring-up sequencer for the TMDS clock: reset pulse, lock qualification
// with timeout and retries, run-time relock and mode switching.
module tmds_pll_ctrl
  import tmds_pll_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int DEFAULT_MODE        = 0
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic [MODE_W-1:0] mode_req,
  input  logic              mode_valid,
  output logic              mode_ready,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic [SEL_W-1:0]  pll_idsel,
  output logic [SEL_W-1:0]  pll_fbdsel,
  output logic [SEL_W-1:0]  pll_odsel,
  output logic [MODE_W-1:0] cur_mode,
  output logic              clk_ready,
  output logic              serdes_rst,
  output logic              fail,
  output logic [1:0]        retry_cnt
);

  localparam int MAX_A   = (RESET_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RESET_HOLD_CYCLES
                                                                    : LOCK_STABLE_CYCLES;
  localparam int MAX_CNT = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

  state_t            r_state;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic [CNT_W-1:0]  r_stab_cnt;
  logic [CNT_W-1:0]  r_to_cnt;
  logic [1:0]        r_retry;
  logic [MODE_W-1:0] r_mode;
  pll_sel_t          r_sel;
  logic              r_pll_reset;
  logic              r_clk_ready;
  logic              r_serdes_rst;
  logic              r_fail;
  logic              r_mode_ready;
  logic              w_lock_s;
  logic              w_accept;

  sync_2ff u_lock_sync (
    .i_clk (clkin),
    .i_rst (reset),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

  // mode_ready is high exactly in RUN and FAIL, so it alone qualifies a request.
  assign w_accept = mode_valid & r_mode_ready;

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state      <= ST_RESET_HOLD;
      r_hold_cnt   <= '0;
      r_stab_cnt   <= '0;
      r_to_cnt     <= '0;
      r_retry      <= '0;
      r_mode       <= MODE_W'(DEFAULT_MODE);
      r_sel        <= MODE_TABLE[MODE_W'(DEFAULT_MODE)];
      r_pll_reset  <= 1'b1;
      r_clk_ready  <= 1'b0;
      r_serdes_rst <= 1'b1;
      r_fail       <= 1'b0;
      r_mode_ready <= 1'b0;
    end else if (w_accept) begin
      // A mode request outranks a simultaneous lock loss: one restart only.
      r_mode       <= mode_req;
      r_sel        <= MODE_TABLE[mode_req];
      r_retry      <= '0;
      r_fail       <= 1'b0;
      r_state      <= ST_RESET_HOLD;
      r_hold_cnt   <= '0;
      r_pll_reset  <= 1'b1;
      r_clk_ready  <= 1'b0;
      r_serdes_rst <= 1'b1;
      r_mode_ready <= 1'b0;
    end else begin
      unique case (r_state)
        ST_RESET_HOLD: begin
          if (r_hold_cnt >= HOLD_LAST) begin
            r_state     <= ST_WAIT_LOCK;
            r_pll_reset <= 1'b0;
            r_to_cnt    <= '0;
          end else begin
            r_hold_cnt <= sat_inc(r_hold_cnt, HOLD_LAST);
          end
        end
        ST_WAIT_LOCK, ST_STABLE: begin
          if (r_to_cnt >= TO_LAST) begin
            if (int'(r_retry) < MAX_RETRIES && r_retry != 2'b11) begin
              r_retry     <= r_retry + 2'd1;
              r_state     <= ST_RESET_HOLD;
              r_hold_cnt  <= '0;
              r_pll_reset <= 1'b1;
            end else begin
              r_state      <= ST_FAIL;
              r_fail       <= 1'b1;
              r_pll_reset  <= 1'b1;
              r_mode_ready <= 1'b1;
            end
          end else begin
            r_to_cnt <= sat_inc(r_to_cnt, TO_LAST);
            if (r_state == ST_WAIT_LOCK) begin
              if (w_lock_s) begin
                r_state    <= ST_STABLE;
                r_stab_cnt <= '0;
              end
            end else if (!w_lock_s) begin
              r_state    <= ST_WAIT_LOCK;
              r_stab_cnt <= '0;
            end else if (r_stab_cnt >= STAB_LAST) begin
              r_state      <= ST_RUN;
              r_clk_ready  <= 1'b1;
              r_serdes_rst <= 1'b0;
              r_mode_ready <= 1'b1;
            end else begin
              r_stab_cnt <= sat_inc(r_stab_cnt, STAB_LAST);
            end
          end
        end
        ST_RUN: begin
          if (!w_lock_s) begin
            r_retry      <= '0;
            r_state      <= ST_RESET_HOLD;
            r_hold_cnt   <= '0;
            r_pll_reset  <= 1'b1;
            r_clk_ready  <= 1'b0;
            r_serdes_rst <= 1'b1;
            r_mode_ready <= 1'b0;
          end
        end
        ST_FAIL: begin
          r_pll_reset <= 1'b1;
        end
        default: begin
          r_state      <= ST_RESET_HOLD;
          r_hold_cnt   <= '0;
          r_pll_reset  <= 1'b1;
          r_clk_ready  <= 1'b0;
          r_serdes_rst <= 1'b1;
          r_mode_ready <= 1'b0;
        end
      endcase
    end
  end

  assign mode_ready = r_mode_ready;
  assign pll_reset  = r_pll_reset;
  assign pll_idsel  = r_sel.idsel;
  assign pll_fbdsel = r_sel.fbdsel;
  assign pll_odsel  = r_sel.odsel;
  assign cur_mode   = r_mode;
  assign clk_ready  = r_clk_ready;
  assign serdes_rst = r_serdes_rst;
  assign fail       = r_fail;
  assign retry_cnt  = r_retry;

endmodule
